// File: rtl/dcache_resp_pkg.sv
// Shared types and defaults for the data-cache responder: FSM state encoding, bus widths,
// default depth and latency.
package dcache_resp_pkg;
   localparam int DATA_W          = 32;
   localparam int ADDR_W          = 32;
   localparam int DEF_DEPTH_WORDS = 256;
   localparam int DEF_LATENCY     = 2;
   localparam int CNT_W           = 3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      RESP      = 2'd2
   } state_t;
endpackage

// File: rtl/dcache_resp_ram.sv
// Word storage for the responder: one synchronous write port and one synchronous read port.
// Contents are never reset; the read register holds its value while i_re is low.
module dcache_resp_ram
   import dcache_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);
   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/dcache_responder.sv
// Single-outstanding data-cache responder: writes complete at acceptance, reads return after LATENCY cycles.
// Ready only while idle; requests seen while busy are dropped. DCACHE_RESP_ERR_EN adds address fault checking.
module dcache_responder
   import dcache_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int LATENCY     = DEF_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] dCacheAddr,
   input  logic [DATA_W-1:0] dCacheWriteData,
   input  logic              dCacheWriteEn,
   input  logic              dCacheReadEn,
   output logic [DATA_W-1:0] dCacheReadData,
   output logic              dCacheReady,
   output logic              dCacheValid,
   output logic              dCacheErr
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic              r_err;
   logic              w_ready;
   logic              w_conflict;
   logic              w_acc_wr;
   logic              w_acc_rd;
   logic              w_fault;
   logic              w_ram_re;
   logic [IDX_W-1:0]  w_idx;
   logic [IDX_W-1:0]  w_ram_raddr;
   logic [DATA_W-1:0] w_ram_q;

   assign w_idx = dCacheAddr[IDX_W+1:2];

`ifdef DCACHE_RESP_ERR_EN
   logic r_fault;
   assign w_fault = (dCacheAddr[1:0] != 2'b00) || (dCacheAddr[ADDR_W-1:IDX_W+2] != '0);
`else
   logic w_unused_addr;
   assign w_fault       = 1'b0;
   assign w_unused_addr = ^{dCacheAddr[ADDR_W-1:IDX_W+2], dCacheAddr[1:0]};
`endif

   assign w_ready    = (r_state == IDLE) && !rst;
   assign w_conflict = w_ready && dCacheWriteEn && dCacheReadEn;
   assign w_acc_wr   = w_ready && dCacheWriteEn && !dCacheReadEn;
   assign w_acc_rd   = w_ready && dCacheReadEn && !dCacheWriteEn;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (w_acc_rd) w_next = (LATENCY == 1) ? RESP : READ_WAIT;
         READ_WAIT: if (r_cnt == '0) w_next = RESP;
         RESP:      w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_acc_rd) begin
         r_cnt <= CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);
      end else if ((r_state == READ_WAIT) && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_acc_rd) r_idx <= w_idx;
         r_err <= w_conflict || (w_acc_wr && w_fault);
      end
   end

`ifdef DCACHE_RESP_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_fault <= 1'b0;
      else if (w_acc_rd) r_fault <= w_fault;
   end
`endif

   // Array read fires on the edge entering RESP; with LATENCY=1 that is the acceptance edge itself.
   assign w_ram_re    = (w_next == RESP) && (r_state != RESP);
   assign w_ram_raddr = (r_state == IDLE) ? w_idx : r_idx;

   dcache_resp_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_acc_wr && !w_fault),
      .i_waddr (w_idx),
      .i_wdata (dCacheWriteData),
      .i_re    (w_ram_re),
      .i_raddr (w_ram_raddr),
      .o_rdata (w_ram_q)
   );

   assign dCacheReady = w_ready;
   assign dCacheValid = (r_state == RESP);

`ifdef DCACHE_RESP_ERR_EN
   assign dCacheReadData = (dCacheValid && !r_fault) ? w_ram_q : '0;
   assign dCacheErr      = r_err || (dCacheValid && r_fault);
`else
   assign dCacheReadData = dCacheValid ? w_ram_q : '0;
   assign dCacheErr      = r_err;
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// Bench: three responders (LATENCY 1, 2, 3) share one stimulus stream; each is compared every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_dcache_responder;
   localparam int DEPTH = 256;
   localparam int NI    = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [31:0] rdata [NI];
   logic        ready [NI];
   logic        valid [NI];
   logic        err   [NI];

   int checks   = 0;
   int failures = 0;

   // Model: per instance, cycles left until ready again; response is due when one cycle is left.
   int          m_busy   [NI];
   bit          m_errf   [NI];
   bit          m_pfault [NI];
   logic [31:0] m_pdata  [NI];
   logic [31:0] m_mem    [NI][DEPTH];

   always #5 clk = ~clk;

   dcache_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .dCacheAddr(addr), .dCacheWriteData(wdata),
      .dCacheWriteEn(we), .dCacheReadEn(re), .dCacheReadData(rdata[0]),
      .dCacheReady(ready[0]), .dCacheValid(valid[0]), .dCacheErr(err[0]));
   dcache_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst), .dCacheAddr(addr), .dCacheWriteData(wdata),
      .dCacheWriteEn(we), .dCacheReadEn(re), .dCacheReadData(rdata[1]),
      .dCacheReady(ready[1]), .dCacheValid(valid[1]), .dCacheErr(err[1]));
   dcache_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst), .dCacheAddr(addr), .dCacheWriteData(wdata),
      .dCacheWriteEn(we), .dCacheReadEn(re), .dCacheReadData(rdata[2]),
      .dCacheReady(ready[2]), .dCacheValid(valid[2]), .dCacheErr(err[2]));

   function automatic bit addr_fault(input logic [31:0] a);
`ifdef DCACHE_RESP_ERR_EN
      return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   function automatic logic [31:0] pre(input int i);
      return 32'hC0DE0000 ^ (32'(i) * 32'h00010003);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
      we = w; re = r; addr = a; wdata = d;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      bit          er, ev, ee;
      logic [31:0] ed;
      for (int k = 0; k < NI; k++) begin
         er = !rst && (m_busy[k] == 0);
         ev = !rst && (m_busy[k] == 1);
         ed = (ev && !m_pfault[k]) ? m_pdata[k] : 32'h0;
         ee = !rst && (m_errf[k] || (ev && m_pfault[k]));
         check($sformatf("ready_L%0d", k + 1), 32'(ready[k]), 32'(er));
         check($sformatf("valid_L%0d", k + 1), 32'(valid[k]), 32'(ev));
         check($sformatf("rdata_L%0d", k + 1), rdata[k], ed);
         check($sformatf("err_L%0d", k + 1), 32'(err[k]), 32'(ee));
      end
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            m_busy[k] = 0;
            m_errf[k] = 1'b0;
         end else begin
            m_errf[k] = 1'b0;
            if (m_busy[k] > 0) begin
               m_busy[k]--;
            end else if (we && re) begin
               m_errf[k] = 1'b1;
            end else if (we) begin
               if (addr_fault(addr)) m_errf[k] = 1'b1;
               else                  m_mem[k][widx(addr)] = wdata;
            end else if (re) begin
               m_busy[k]   = k + 1;
               m_pfault[k] = addr_fault(addr);
               m_pdata[k]  = m_pfault[k] ? 32'h0 : m_mem[k][widx(addr)];
            end
         end
      end
   end

   initial begin
      logic [31:0] vmask;
      int          nv;
      logic [31:0] a;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready[1]), 32'h0);
      check("rst_valid", 32'(valid[1]), 32'h0);
      check("rst_rdata", rdata[1], 32'h0);
      check("rst_err", 32'(err[1]), 32'h0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(ready[1]), 32'h1);

      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'(i * 4), pre(i));
      repeat (2) step(1'b0, 1'b0, 32'h0, 32'h0);

      // Write then read 0x10 on LATENCY=2
      step(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
      step(1'b0, 1'b1, 32'h10, 32'h0);
      check("rd10_ready_n1", 32'(ready[1]), 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      check("rd10_valid_n2", 32'(valid[1]), 32'h1);
      check("rd10_data_n2", rdata[1], 32'hDEADBEEF);
      check("rd10_ready_n2", 32'(ready[1]), 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      check("rd10_ready_n3", 32'(ready[1]), 32'h1);
      repeat (4) step(1'b0, 1'b0, 32'h0, 32'h0);

      // LATENCY=1 write-then-read forwarding
      step(1'b1, 1'b0, 32'h0, 32'h12345678);
      step(1'b0, 1'b1, 32'h0, 32'h0);
      check("l1_valid", 32'(valid[0]), 32'h1);
      check("l1_data", rdata[0], 32'h12345678);
      repeat (5) step(1'b0, 1'b0, 32'h0, 32'h0);

      // Simultaneous read and write
      step(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF);
      check("conflict_err", 32'(err[1]), 32'h1);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      check("conflict_err_gone", 32'(err[1]), 32'h0);
      repeat (4) step(1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b1, 32'h20, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      check("conflict_kept", rdata[1], pre(8));
      repeat (4) step(1'b0, 1'b0, 32'h0, 32'h0);

      // Held read on LATENCY=3; address swapped while not ready must be ignored
      vmask = '0;
      nv    = 0;
      for (int i = 0; i < 13; i++) begin
         if (i < 10) step(1'b0, 1'b1, ((i % 4) == 0) ? 32'h40 : 32'h80, 32'h0);
         else        step(1'b0, 1'b0, 32'h0, 32'h0);
         if (valid[2]) begin
            vmask[i+1] = 1'b1;
            nv++;
            check("held_rd_data", rdata[2], pre(16));
         end
      end
      check("held_rd_pulses", vmask, 32'h0000_0888);
      check("held_rd_count", 32'(nv), 32'd3);
      repeat (5) step(1'b0, 1'b0, 32'h0, 32'h0);

      // Reset mid-read
      step(1'b0, 1'b1, 32'h40, 32'h0);
      rst = 1'b1;
      #1;
      check("midrst_valid", 32'(valid[2]), 32'h0);
      check("midrst_ready", 32'(ready[2]), 32'h0);
      check("midrst_rdata", rdata[2], 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_ready_after", 32'(ready[2]), 32'h1);
      nv = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 32'h0, 32'h0);
         nv += int'(valid[0]) + int'(valid[1]) + int'(valid[2]);
      end
      check("midrst_no_valid", 32'(nv), 32'd0);

      // Address checking behaviour
      step(1'b1, 1'b0, 32'h6, 32'h5);
`ifdef DCACHE_RESP_ERR_EN
      check("misaligned_wr_err", 32'(err[1]), 32'h1);
`else
      check("misaligned_wr_err", 32'(err[1]), 32'h0);
`endif
      repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b1, 32'h400, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      check("rd400_valid", 32'(valid[1]), 32'h1);
`ifdef DCACHE_RESP_ERR_EN
      check("rd400_err", 32'(err[1]), 32'h1);
      check("rd400_data", rdata[1], 32'h0);
`else
      check("rd400_err", 32'(err[1]), 32'h0);
      check("rd400_data", rdata[1], 32'h12345678);
`endif
      repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b1, 32'h4, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
`ifdef DCACHE_RESP_ERR_EN
      check("rd4_after_bad_wr", rdata[1], pre(1));
`else
      check("rd4_after_bad_wr", rdata[1], 32'h5);
`endif
      repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0);

      // Randomized traffic with occasional reset pulses
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 4) == 0) a = $urandom;
         else                           a = {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
         step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, a, $urandom);
      end
      rst = 1'b0;
      repeat (6) step(1'b0, 1'b0, 32'h0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dcache_responder.md
DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored; power of two, 16..4096.
REQ-002 Parameter LATENCY, default 2, cycles from read acceptance to read-data valid; range 1..7.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 dCacheAddr  input  32  byte address from core; word index is bits [log2(DEPTH_WORDS)+1:2].
REQ-006 dCacheWriteData  input  32  store data.
REQ-007 dCacheWriteEn  input  1  store request.
REQ-008 dCacheReadEn  input  1  load request.
REQ-009 dCacheReadData  output  32  load data, meaningful only while dCacheValid=1.
REQ-010 dCacheReady  output  1  responder accepts a request this cycle.
REQ-011 dCacheValid  output  1  one-cycle pulse marking returned load data.
REQ-012 dCacheErr  output  1  one-cycle pulse marking a rejected or faulting request.

Function
REQ-013 FSM states: IDLE, READ_WAIT, RESP; dCacheReady=1 only in IDLE.
REQ-014 A request is accepted only in a cycle with dCacheReady=1; requests while dCacheReady=0 are ignored, with no queuing.
REQ-015 Accepted write (WriteEn=1, ReadEn=0): word written at that edge; state stays IDLE; dCacheReady stays 1.
REQ-016 Accepted read (ReadEn=1, WriteEn=0) in cycle N: address latched; dCacheValid=1 with data in cycle N+LATENCY; dCacheReady=0 in cycles N+1..N+LATENCY.
REQ-017 LATENCY=1: IDLE goes directly to RESP; LATENCY>1: IDLE to READ_WAIT, a down-counter loaded with LATENCY-2, then RESP when the counter reaches 0.
REQ-018 RESP always returns to IDLE on the next edge, so back-to-back reads are spaced LATENCY+1 cycles apart.
REQ-019 A read accepted the cycle after a write to the same word returns the newly written data.
REQ-020 WriteEn=1 and ReadEn=1 together while ready: no memory change, no read; dCacheErr pulses in the next cycle; state stays IDLE.
REQ-021 dCacheReadData=0 in every cycle where dCacheValid=0.

Reset
REQ-022 While rst=1: state IDLE, counter 0, dCacheReadData=0, dCacheValid=0, dCacheErr=0, dCacheReady=0.
REQ-023 dCacheReady=1 in the first cycle after rst deasserts.
REQ-024 Reset during READ_WAIT or RESP abandons the read; no dCacheValid pulse follows.
REQ-025 Memory contents are not reset.

Configuration
REQ-026 Macro DCACHE_RESP_ERR_EN defined enables address checking as follows.
REQ-027 A request with addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS raises dCacheErr.
REQ-028 A faulting write is dropped, with dCacheErr in the next cycle.
REQ-029 A faulting read completes with normal timing, dCacheReadData=0, and dCacheErr=1 in the same cycle as dCacheValid.
REQ-030 Macro undefined: dCacheErr is driven only by REQ-020.
REQ-031 Macro undefined: addr[1:0] is ignored and the word index wraps modulo DEPTH_WORDS.

Structure
REQ-032 Package dcache_resp_pkg holds the state enum (IDLE, READ_WAIT, RESP), DATA_W=32, ADDR_W=32, and default DEPTH_WORDS/LATENCY.
REQ-033 Sub-module dcache_resp_ram provides storage with one synchronous write port and one synchronous read port; the FSM, counter and checks stay in dcache_responder.

Verification
REQ-034 Write 0xDEADBEEF to 0x10, then read 0x10 with LATENCY=2 (read accepted cycle N) -> dCacheValid=1 with data 0xDEADBEEF in cycle N+2, and dCacheReady=0 in cycles N+1..N+2.
REQ-035 LATENCY=1: write 0x12345678 to 0x0 in cycle N, read 0x0 in cycle N+1 -> data 0x12345678 valid in cycle N+2.
REQ-036 ReadEn=1 and WriteEn=1 at 0x20 with data 0xFFFFFFFF -> dCacheErr pulse; a later read of 0x20 returns the prior value.
REQ-037 A read held asserted for 10 cycles with LATENCY=3 -> dCacheValid pulses at 4-cycle spacing; a new address applied while dCacheReady=0 is ignored.
REQ-038 rst asserted mid-READ_WAIT -> outputs 0 immediately; no dCacheValid pulse; dCacheReady=1 one cycle after release.
REQ-039 DCACHE_RESP_ERR_EN defined: write 0x5 to 0x6 -> dropped with dCacheErr; read 0x400 at DEPTH_WORDS=256 -> dCacheValid and dCacheErr with data 0; macro undefined, read 0x400 -> returns the word at index 0.
